// File: rtl/switch_debounce.sv
// Switch-bus conditioner: two-flop synchronizer, slow sample tick, and per-bit
// stability counters. Produces a clean bus plus one-cycle rise/fall/change strobes.
module switch_debounce #(
  parameter int WIDTH          = 18,
  parameter int SAMPLE_DIV     = 50000,
  parameter int STABLE_SAMPLES = 4
) (
  input  logic             CLOCK_50_I,
  input  logic             RESETN_I,
  input  logic [WIDTH-1:0] SWITCH_I,
  output logic [WIDTH-1:0] SWITCH_O,
  output logic [WIDTH-1:0] RISE_O,
  output logic [WIDTH-1:0] FALL_O,
  output logic             CHANGE_O,
  output logic             TICK_O
);

  localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int CNT_W = (STABLE_SAMPLES > 0) ? $clog2(STABLE_SAMPLES + 1) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_SAMPLES - 1);

  logic [DIV_W-1:0]            div_cnt_q, div_cnt_d;
  logic                        tick_q, tick_d;
  logic [WIDTH-1:0]            sync1_q, sync2_q;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]            sw_q, sw_d;
  logic [WIDTH-1:0]            rise_q, rise_d;
  logic [WIDTH-1:0]            fall_q, fall_d;
  logic                        change_q, change_d;

  // The tick flop is loaded from the next divider value so it is high exactly
  // while div_cnt_q sits at its last count, yet stays a clean register output.
  always_comb begin
    div_cnt_d = div_cnt_q;
    if (div_cnt_q == DIV_LAST) begin
      div_cnt_d = '0;
    end else begin
      div_cnt_d = div_cnt_q + DIV_W'(1'b1);
    end
    tick_d = (div_cnt_d == DIV_LAST);
  end

  // Per-bit qualification: any sample at the accepted level restarts the count.
  always_comb begin
    sw_d   = sw_q;
    cnt_d  = cnt_q;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (!tick_q) begin
        cnt_d[i] = cnt_q[i];
      end else if (sync2_q[i] == sw_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        sw_d[i]   = sync2_q[i];
        cnt_d[i]  = '0;
        rise_d[i] = sync2_q[i];
        fall_d[i] = ~sync2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1'b1);
      end
    end
    change_d = (|rise_d) | (|fall_d);
  end

  // State register with asynchronous clear of every flop.
  always_ff @(posedge CLOCK_50_I or negedge RESETN_I) begin
    if (!RESETN_I) begin
      div_cnt_q <= '0;
      tick_q    <= 1'b0;
      sync1_q   <= '0;
      sync2_q   <= '0;
      cnt_q     <= '0;
      sw_q      <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      change_q  <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      tick_q    <= tick_d;
      sync1_q   <= SWITCH_I;
      sync2_q   <= sync1_q;
      cnt_q     <= cnt_d;
      sw_q      <= sw_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      change_q  <= change_d;
    end
  end

  assign SWITCH_O = sw_q;
  assign RISE_O   = rise_q;
  assign FALL_O   = fall_q;
  assign CHANGE_O = change_q;
  assign TICK_O   = tick_q;

endmodule

// File: tb/tb_switch_debounce.sv
// Directed bench for switch_debounce with SAMPLE_DIV=4, STABLE_SAMPLES=3.
// Cycle k means the interval after the k-th rising edge following reset release.
module tb_switch_debounce;

  logic        clk;
  logic        rst_n;
  logic [17:0] switch_i;
  logic [17:0] switch_o;
  logic [17:0] rise_o;
  logic [17:0] fall_o;
  logic        change_o;
  logic        tick_o;

  int passed;
  int total;
  int cyc_now;
  int chg_cnt;

  switch_debounce #(
    .WIDTH(18),
    .SAMPLE_DIV(4),
    .STABLE_SAMPLES(3)
  ) dut (
    .CLOCK_50_I(clk),
    .RESETN_I(rst_n),
    .SWITCH_I(switch_i),
    .SWITCH_O(switch_o),
    .RISE_O(rise_o),
    .FALL_O(fall_o),
    .CHANGE_O(change_o),
    .TICK_O(tick_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
  endtask

  task automatic rel();
    @(posedge clk);
    #2 rst_n = 1'b1;
    cyc_now = 0;
  endtask

  task automatic adv_to(input int k);
    while (cyc_now < k) begin
      @(posedge clk);
      cyc_now++;
    end
    #1;
  endtask

  initial begin
    passed   = 0;
    total    = 0;
    cyc_now  = 0;
    chg_cnt  = 0;
    switch_i = 18'h00000;
    rst_n    = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("init_sw", switch_o, 64'h0);
    chk("init_tick", tick_o, 64'h0);

    // Clean rise on bit 3
    switch_i = 18'h00008;
    rel();
    adv_to(2);  chk("tick_c2", tick_o, 64'h0);
    adv_to(3);  chk("tick_c3", tick_o, 64'h1);
    adv_to(4);  chk("tick_c4", tick_o, 64'h0);
    adv_to(7);  chk("tick_c7", tick_o, 64'h1);
    adv_to(11); chk("rise_c11_sw", switch_o, 64'h0);
    adv_to(12);
    chk("rise_c12_sw", switch_o, 64'h8);
    chk("rise_c12_rise", rise_o, 64'h8);
    chk("rise_c12_fall", fall_o, 64'h0);
    chk("rise_c12_chg", change_o, 64'h1);
    adv_to(13);
    chk("rise_c13_sw", switch_o, 64'h8);
    chk("rise_c13_rise", rise_o, 64'h0);
    chk("rise_c13_chg", change_o, 64'h0);

    // Bounce on bit 0 spanning ticks 15 and 19 only
    switch_i[0] = 1'b1;
    for (int c = 14; c <= 30; c++) begin
      adv_to(c);
      if (c == 19) switch_i[0] = 1'b0;
      chk("bounce_sw", switch_o, 64'h8);
      chk("bounce_strobe", {rise_o, change_o}, 64'h0);
    end

    // Restart on bounce, bit 5: high ticks 35,39, low tick 43, high ticks 47,51,55
    switch_i[5] = 1'b1;
    adv_to(40); switch_i[5] = 1'b0;
    adv_to(43); switch_i[5] = 1'b1;
    adv_to(48); chk("restart_c48_sw", switch_o, 64'h08);
    adv_to(55); chk("restart_c55_sw", switch_o, 64'h08);
    adv_to(56);
    chk("restart_c56_sw", switch_o, 64'h28);
    chk("restart_c56_rise", rise_o, 64'h20);
    chk("restart_c56_chg", change_o, 64'h1);

    // Asynchronous reset mid-count with SWITCH_O = 5
    rst_n = 1'b0;
    #2;
    switch_i = 18'h00005;
    rel();
    adv_to(12); chk("rst_pre_sw", switch_o, 64'h5);
    adv_to(15);
    chk("rst_pre_tick", tick_o, 64'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_sw", switch_o, 64'h0);
    chk("rst_rise", rise_o, 64'h0);
    chk("rst_fall", fall_o, 64'h0);
    chk("rst_chg", change_o, 64'h0);
    chk("rst_tick", tick_o, 64'h0);
    rel();
    adv_to(2);  chk("rst_tick_c2", tick_o, 64'h0);
    adv_to(3);  chk("rst_tick_c3", tick_o, 64'h1);
    adv_to(11); chk("rst_c11_sw", switch_o, 64'h0);
    adv_to(12);
    chk("rst_c12_sw", switch_o, 64'h5);
    chk("rst_c12_rise", rise_o, 64'h5);

    // Simultaneous rise on bit 17 and fall on bit 0
    rst_n = 1'b0;
    #2;
    switch_i = 18'h00001;
    rel();
    adv_to(12); chk("sim_pre_sw", switch_o, 64'h1);
    switch_i = 18'h20000;
    for (int c = 13; c <= 30; c++) begin
      adv_to(c);
      if (change_o === 1'b1) chg_cnt++;
      if (c == 23) chk("sim_c23_sw", switch_o, 64'h1);
      if (c == 24) begin
        chk("sim_c24_sw", switch_o, 64'h20000);
        chk("sim_c24_rise", rise_o, 64'h20000);
        chk("sim_c24_fall", fall_o, 64'h1);
        chk("sim_c24_chg", change_o, 64'h1);
      end
      if (c == 25) chk("sim_c25_strobes", {rise_o, fall_o, change_o}, 64'h0);
    end
    chk("sim_chg_count", chg_cnt, 64'h1);

    // Reset mid-qualification on bit 7
    rst_n = 1'b0;
    #2;
    switch_i = 18'h00080;
    rel();
    adv_to(8);
    rst_n = 1'b0;
    #1;
    chk("midq_rst_sw", switch_o, 64'h0);
    rel();
    adv_to(4);  chk("midq_c4_sw", switch_o, 64'h0);
    adv_to(11); chk("midq_c11_sw", switch_o, 64'h0);
    adv_to(12);
    chk("midq_c12_sw", switch_o, 64'h80);
    chk("midq_c12_rise", rise_o, 64'h80);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
